uart_frame_responder: RTL and testbench

- Sensor-side end of the measurement-request link: waits for a request pulse (high then low) on the request line driven by TheFFM, then transmits one fixed-length frame on a UART TX line.
- Frame is built from sync bytes plus latched sample bytes; 8N1, LSB first.
- Used as a synthesizable sensor emulator on the bench and on test hardware.
- One instance per UART channel (UART1/3/4/5).

---
 rtl/uart_frame_responder.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_responder.sv
// uart_frame_responder
// Sensor-side emulator for the measurement-request link. The block waits for a
// high->low transition on the request line. It then latches the sample bytes and
// sends one fixed-length 8N1 frame, LSB first, on a UART TX line. Byte 0 of each
// group is the sync marker. The remaining bytes carry the latched samples in order.
//
// Ports:
//   clk80      system clock (BIT_CLKS cycles per UART bit)
//   rst_n      synchronous active-low reset
//   iReq       request line, asynchronous to clk80
//   iSamples   sample bytes; sample s = bits [8s+7:8s]
//   oTx        UART TX line, idle high
//   oBusy      high from request detection through the last stop bit
//   oFrameDone one-cycle pulse at the end of the final stop bit
//   oMissed    one-cycle pulse for a request edge that arrives while busy
module uart_frame_responder #(
  parameter int         BIT_CLKS    = 16,
  parameter int         FRAME_LEN   = 15,
  parameter int         GROUP_LEN   = 5,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         START_DELAY = 1,
  localparam int        NSAMP       = FRAME_LEN - FRAME_LEN / GROUP_LEN
) (
  input  logic               clk80,
  input  logic               rst_n,
  input  logic               iReq,
  input  logic [8*NSAMP-1:0] iSamples,
  output logic               oTx,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oMissed
);

  localparam int CNT_W  = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int BYTE_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DLY_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_LEN - 1);
  localparam logic [BYTE_W-1:0] GROUP_V   = BYTE_W'(GROUP_LEN);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_s1, r_s2, r_p, r_fall;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [2:0]         r_bit_idx;
  logic [BYTE_W-1:0]  r_byte_idx;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic [8*NSAMP-1:0] r_samples;
  logic               r_tx, r_busy, r_done, r_missed;

  logic               w_fall;
  logic               w_wrap;
  logic [2:0]         w_next_bit;
  logic [BYTE_W-1:0]  w_samp_idx;
  logic [7:0]         w_cur_byte;

  assign w_fall     = r_p & ~r_s2;
  assign w_wrap     = (r_bit_cnt == CNT_LAST);
  assign w_next_bit = r_bit_idx + 3'd1;

  // Request synchronizer. The falling edge is registered once more, so the FSM
  // reacts one edge after detection.
  always_ff @(posedge clk80) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_p    <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= iReq;
      r_s2   <= r_s1;
      r_p    <= r_s2;
      r_fall <= w_fall;
    end
  end

  // Byte selection: sync marker at the start of each group, otherwise the next
  // latched sample. Sample index = byte index minus the sync bytes seen so far.
  always_comb begin
    w_samp_idx = r_byte_idx - (r_byte_idx / GROUP_V) - BYTE_W'(1);
    if ((r_byte_idx % GROUP_V) == '0) begin
      w_cur_byte = SYNC_BYTE;
    end else begin
      w_cur_byte = r_samples[{w_samp_idx, 3'b000} +: 8];
    end
  end

  // Frame FSM. oTx is registered, so each transition loads the level for the next bit.
  always_ff @(posedge clk80) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= '0;
      r_dly_cnt  <= '0;
      r_samples  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      // A request in the frame-done cycle counts as missed, not as a new frame.
      r_missed <= r_fall & ((r_state != S_IDLE) | r_done);
      if (r_state != S_IDLE) begin
        r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + CNT_W'(1);
      end else begin
        r_bit_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (r_fall && !r_done) begin
            r_busy     <= 1'b1;
            r_samples  <= iSamples;
            r_byte_idx <= '0;
            r_bit_idx  <= 3'd0;
            r_dly_cnt  <= '0;
            if (START_DELAY == 0) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          r_tx <= 1'b1;
          if (w_wrap) begin
            if (r_dly_cnt == DLY_LAST) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_dly_cnt <= r_dly_cnt + DLY_W'(1);
            end
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_tx      <= w_cur_byte[0];
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= w_next_bit;
              r_tx      <= w_cur_byte[w_next_bit];
            end
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            if (r_byte_idx != BYTE_LAST) begin
              r_byte_idx <= r_byte_idx + BYTE_W'(1);
              r_state    <= S_START;
              r_tx       <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oTx        = r_tx;
  assign oBusy      = r_busy;
  assign oFrameDone = r_done;
  assign oMissed    = r_missed;

endmodule

// File: tb/tb_uart_frame_responder.sv
module tb_uart_frame_responder;

  localparam int NSAMP = 12;
  localparam int FLEN  = 15;

  logic             clk80;
  logic             rst_n;
  logic             iReq;
  logic [8*NSAMP-1:0] iSamples;
  logic             oTx, oBusy, oFrameDone, oMissed;

  int n_vec;
  int n_err;

  uart_frame_responder dut (
    .clk80      (clk80),
    .rst_n      (rst_n),
    .iReq       (iReq),
    .iSamples   (iSamples),
    .oTx        (oTx),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone),
    .oMissed    (oMissed)
  );

  initial clk80 = 1'b0;
  always #5 clk80 = ~clk80;

  typedef struct {
    logic [95:0] samp;
    bit          change;
    bit          mid_req;
    logic [7:0]  exp [FLEN];
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame built by walking the bytes and handing out samples in order.
  task automatic model(input logic [95:0] samp, output logic [7:0] exp [FLEN]);
    int n;
    n = 0;
    for (int b = 0; b < FLEN; b++) begin
      if (b % 5 == 0) begin
        exp[b] = 8'h55;
      end else begin
        exp[b] = samp[8*n +: 8];
        n++;
      end
    end
  endtask

  // One request pulse followed by a cycle-exact decode of the whole frame.
  task automatic run_frame(input string tag, input logic [95:0] samp, input logic [7:0] exp [FLEN],
                           input bit change, input bit mid_req, input int hi);
    logic [7:0] got [FLEN];
    int ferr, done_cnt, done_t, miss_cnt, lat, idle_err, rel, b, w, slot;
    bit seen;
    ferr = 0; done_cnt = 0; done_t = -1; miss_cnt = 0; lat = 0; idle_err = 0; seen = 1'b0;
    for (int i = 0; i < FLEN; i++) got[i] = 8'hxx;
    iSamples = samp;
    iReq = 1'b1;
    repeat (hi) @(negedge clk80);
    iReq = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk80);
      if (oBusy === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk({tag, " busy latency"}, lat, 4);
    if (!seen) return;
    for (int t = 0; t <= 2440; t++) begin
      if (t > 0) @(negedge clk80);
      if (change && t == 1) iSamples = '0;
      if (mid_req && t == 16 + 7*160) iReq = 1'b1;
      if (mid_req && t == 16 + 7*160 + 10) iReq = 1'b0;
      if (oFrameDone === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (oMissed === 1'b1) miss_cnt++;
      if (t < 16 && (oTx !== 1'b1 || oBusy !== 1'b1)) ferr++;
      if (t >= 16 && t < 2416) begin
        rel = t - 16;
        b = rel / 160;
        w = rel % 160;
        slot = w / 16;
        if (w % 16 == 8) begin
          if (slot == 0 && oTx !== 1'b0) ferr++;
          else if (slot == 9 && oTx !== 1'b1) ferr++;
          else if (slot >= 1 && slot <= 8) got[b][slot-1] = oTx;
        end
        if (oBusy !== 1'b1) ferr++;
      end
      if (t >= 2416 && (oTx !== 1'b1 || oBusy !== 1'b0)) idle_err++;
    end
    for (int i = 0; i < FLEN; i++) chk($sformatf("%s byte%0d", tag, i), got[i], exp[i]);
    chk({tag, " framing/busy errors"}, ferr, 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " done time"}, done_t, 2416);
    chk({tag, " missed pulses"}, miss_cnt, mid_req ? 1 : 0);
    chk({tag, " idle after frame"}, idle_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, dc, lat;
    bit seen;
    logic [95:0] rs;
    logic [7:0] ex [FLEN];
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{samp: 96'h9C9B9A99_98979695_94939291, change: 1'b0, mid_req: 1'b0,
                exp: '{8'h55, 8'h91, 8'h92, 8'h93, 8'h94, 8'h55, 8'h95, 8'h96, 8'h97, 8'h98,
                       8'h55, 8'h99, 8'h9A, 8'h9B, 8'h9C}};
    vecs[1] = '{samp: 96'h9C9B9A99_98979695_94939291, change: 1'b1, mid_req: 1'b0,
                exp: '{8'h55, 8'h91, 8'h92, 8'h93, 8'h94, 8'h55, 8'h95, 8'h96, 8'h97, 8'h98,
                       8'h55, 8'h99, 8'h9A, 8'h9B, 8'h9C}};
    vecs[2] = '{samp: 96'h0C0B0A09_08070605_04030201, change: 1'b0, mid_req: 1'b1,
                exp: '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h05, 8'h06, 8'h07, 8'h08,
                       8'h55, 8'h09, 8'h0A, 8'h0B, 8'h0C}};
    vecs[3] = '{samp: 96'h0, change: 1'b0, mid_req: 1'b0,
                exp: '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h55, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{samp: 96'h8001FF7E_5A3CC300_FEEF1234, change: 1'b0, mid_req: 1'b0,
                exp: '{8'h55, 8'h34, 8'h12, 8'hEF, 8'hFE, 8'h55, 8'h00, 8'hC3, 8'h3C, 8'h5A,
                       8'h55, 8'h7E, 8'hFF, 8'h01, 8'h80}};

    // Reset state.
    rst_n = 1'b0;
    iReq = 1'b0;
    iSamples = '0;
    repeat (3) @(negedge clk80);
    chk("reset oTx", oTx, 1);
    chk("reset oBusy", oBusy, 0);
    chk("reset oFrameDone", oFrameDone, 0);
    chk("reset oMissed", oMissed, 0);
    rst_n = 1'b1;

    // Idle with request low, then request held high without a fall.
    errs = 0;
    repeat (1000) begin
      @(negedge clk80);
      if (oTx !== 1'b1 || oBusy !== 1'b0 || oFrameDone !== 1'b0 || oMissed !== 1'b0) errs++;
    end
    chk("idle low", errs, 0);
    errs = 0;
    iReq = 1'b1;
    repeat (500) begin
      @(negedge clk80);
      if (oTx !== 1'b1 || oBusy !== 1'b0 || oFrameDone !== 1'b0 || oMissed !== 1'b0) errs++;
    end
    chk("idle high level", errs, 0);

    // Directed frames.
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].samp, vecs[i].exp, vecs[i].change, vecs[i].mid_req, 10);
    end

    // Reset during byte 4 data bits, then no completion.
    iSamples = vecs[0].samp;
    iReq = 1'b1;
    repeat (2) @(negedge clk80);
    iReq = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk80);
      if (oBusy === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk("rst run busy latency", lat, 4);
    repeat (16 + 4*160 + 16 + 40) @(negedge clk80);
    rst_n = 1'b0;
    @(negedge clk80);
    chk("mid reset oTx", oTx, 1);
    chk("mid reset oBusy", oBusy, 0);
    rst_n = 1'b1;
    errs = 0;
    dc = 0;
    repeat (3000) begin
      @(negedge clk80);
      if (oFrameDone === 1'b1) dc++;
      if (oBusy !== 1'b0 || oTx !== 1'b1) errs++;
    end
    chk("after reset done pulses", dc, 0);
    chk("after reset idle", errs, 0);
    run_frame("post-reset", vecs[4].samp, vecs[4].exp, 1'b0, 1'b0, 2);

    // Back-to-back frames with random samples.
    for (int f = 0; f < 16; f++) begin
      rs = {$urandom, $urandom, $urandom};
      model(rs, ex);
      run_frame($sformatf("soak%0d", f), rs, ex, 1'b0, 1'b0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
